// File: rtl/timer_cmp_pkg.sv
// Shared register map and CTRL/STATUS bit positions for the compare timer.
// Used by the bus decoder here and mirrored by firmware headers.
package timer_cmp_pkg;

   localparam logic [2:0] ADDR_CTRL    = 3'd0;
   localparam logic [2:0] ADDR_STATUS  = 3'd1;
   localparam logic [2:0] ADDR_CMP_LO  = 3'd2;
   localparam logic [2:0] ADDR_CMP_HI  = 3'd3;
   localparam logic [2:0] ADDR_PERIOD  = 3'd4;
   localparam logic [2:0] ADDR_SNAP_LO = 3'd5;
   localparam logic [2:0] ADDR_SNAP_HI = 3'd6;

   localparam int unsigned CTRL_ENABLE_BIT     = 0;
   localparam int unsigned CTRL_AUTORELOAD_BIT = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT     = 2;
   localparam int unsigned STATUS_PENDING_BIT  = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   function automatic logic [31:0] ctrl_word(input logic en, input logic ar, input logic ie);
      logic [31:0] w;
      w = '0;
      w[CTRL_ENABLE_BIT]     = en;
      w[CTRL_AUTORELOAD_BIT] = ar;
      w[CTRL_IRQ_EN_BIT]     = ie;
      return w;
   endfunction

endpackage

// File: rtl/timer_cmp_regs.sv
// Register file, read mux and coherent count snapshot for timer_cmp.
// CTRL.enable itself lives in the top-level state machine and is read back via armed.
module timer_cmp_regs
   import timer_cmp_pkg::*;
#(
   parameter int unsigned WIDTH    = 36,
   parameter int unsigned PERIOD_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    count,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic [2:0]          addr,
   input  logic [31:0]         wdata,
   input  logic                armed,
   input  logic                match,
   input  logic                reload,
   input  logic [WIDTH-1:0]    cmp_reload,
   output logic                ctrl_wr,
   output logic                ctrl_wr_enable,
   output logic                autoreload,
   output logic                irq_en,
   output logic                pending,
   output logic [WIDTH-1:0]    cmp,
   output logic [PERIOD_W-1:0] period,
   output logic [31:0]         rdata,
   output logic                rvalid
);

   localparam int unsigned HI_W = WIDTH - 32;

   logic [HI_W-1:0] snap_hi;
   logic            wr_status, wr_cmp_lo, wr_cmp_hi, wr_period, rd_snap_lo;
   logic [31:0]     rd_mux;

   always_comb begin
      ctrl_wr        = wr_en && (addr == ADDR_CTRL);
      ctrl_wr_enable = wdata[CTRL_ENABLE_BIT];
      wr_status      = wr_en && (addr == ADDR_STATUS);
      wr_cmp_lo      = wr_en && (addr == ADDR_CMP_LO);
      wr_cmp_hi      = wr_en && (addr == ADDR_CMP_HI);
      wr_period      = wr_en && (addr == ADDR_PERIOD);
      rd_snap_lo     = rd_en && (addr == ADDR_SNAP_LO);
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_CTRL:    rd_mux = ctrl_word(armed, autoreload, irq_en);
         ADDR_STATUS:  rd_mux[STATUS_PENDING_BIT] = pending;
         ADDR_CMP_LO:  rd_mux = cmp[31:0];
         ADDR_CMP_HI:  rd_mux = 32'(cmp[WIDTH-1:32]);
         ADDR_PERIOD:  rd_mux = 32'(period);
         ADDR_SNAP_LO: rd_mux = count[31:0];
         ADDR_SNAP_HI: rd_mux = 32'(snap_hi);
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         autoreload <= 1'b0;
         irq_en     <= 1'b0;
         pending    <= 1'b0;
         cmp        <= '0;
         period     <= '0;
         snap_hi    <= '0;
         rdata      <= '0;
         rvalid     <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            autoreload <= wdata[CTRL_AUTORELOAD_BIT];
            irq_en     <= wdata[CTRL_IRQ_EN_BIT];
         end
         // A match in the same cycle as a W1C keeps pending set.
         if (match)
            pending <= 1'b1;
         else if (wr_status && wdata[STATUS_PENDING_BIT])
            pending <= 1'b0;
         // CPU write to either CMP half takes priority over the autoreload step.
         if (wr_cmp_lo)
            cmp[31:0] <= wdata;
         else if (wr_cmp_hi)
            cmp[WIDTH-1:32] <= wdata[HI_W-1:0];
         else if (reload)
            cmp <= cmp_reload;
         if (wr_period)
            period <= wdata[PERIOD_W-1:0];
         if (rd_snap_lo)
            snap_hi <= count[WIDTH-1:32];
         rvalid <= rd_en;
         rdata  <= rd_en ? rd_mux : '0;
      end
   end

endmodule

// File: rtl/timer_cmp.sv
// Compare timer: matches a free-running count against CMP, with one-shot or
// periodic autoreload operation and a level interrupt.
module timer_cmp
   import timer_cmp_pkg::*;
#(
   parameter int unsigned WIDTH    = 36,
   parameter int unsigned PERIOD_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [2:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rvalid,
   output logic             irq
);

   state_t                state;
   logic                  armed, match, reload;
   logic                  ctrl_wr, ctrl_wr_enable;
   logic                  autoreload, irq_en, pending;
   logic [WIDTH-1:0]      cmp, cmp_reload;
   logic [PERIOD_W-1:0]   period;

   always_comb begin
      armed      = (state == ST_ARMED);
      match      = armed && (count == cmp);
      reload     = match && autoreload;
      cmp_reload = cmp + WIDTH'(period);
      irq        = pending && irq_en;
   end

   // An explicit CTRL write in the match cycle overrides the one-shot disarm.
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else if (ctrl_wr)
         state <= ctrl_wr_enable ? ST_ARMED : ST_IDLE;
      else if (match && !autoreload)
         state <= ST_IDLE;
   end

   timer_cmp_regs #(
      .WIDTH    (WIDTH),
      .PERIOD_W (PERIOD_W)
   ) u_regs (
      .clk            (clk),
      .reset          (reset),
      .count          (count),
      .wr_en          (wr_en),
      .rd_en          (rd_en),
      .addr           (addr),
      .wdata          (wdata),
      .armed          (armed),
      .match          (match),
      .reload         (reload),
      .cmp_reload     (cmp_reload),
      .ctrl_wr        (ctrl_wr),
      .ctrl_wr_enable (ctrl_wr_enable),
      .autoreload     (autoreload),
      .irq_en         (irq_en),
      .pending        (pending),
      .cmp            (cmp),
      .period         (period),
      .rdata          (rdata),
      .rvalid         (rvalid)
   );

endmodule

// File: tb/tb_timer_cmp.sv
// Directed self-checking bench for timer_cmp with hand-computed expectations.
module tb_timer_cmp;

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_STATUS  = 3'd1;
   localparam logic [2:0] A_CMP_LO  = 3'd2;
   localparam logic [2:0] A_CMP_HI  = 3'd3;
   localparam logic [2:0] A_PERIOD  = 3'd4;
   localparam logic [2:0] A_SNAP_LO = 3'd5;
   localparam logic [2:0] A_SNAP_HI = 3'd6;
   localparam logic [2:0] A_RSVD    = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [35:0] count = '0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [2:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   timer_cmp #(
      .WIDTH    (36),
      .PERIOD_W (32)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .count  (count),
      .wr_en  (wr_en),
      .rd_en  (rd_en),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .rvalid (rvalid),
      .irq    (irq)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         count = count + 36'd1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr_en = 1'b0; wdata = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
      @(negedge clk);
      rd_en = 1'b1; addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      d = rdata; v = rvalid;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        v;
      logic [2:0]  addrs [7];
      addrs = '{A_CTRL, A_STATUS, A_CMP_LO, A_CMP_HI, A_PERIOD, A_SNAP_HI, A_RSVD};
      repeat (2) @(negedge clk);
      reset = 1'b0;
      vectors++;
      if ({rvalid, rdata, irq} !== 34'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: rvalid=%b rdata=%h irq=%b expected all 0", rvalid, rdata, irq);
      end
      for (int i = 0; i < 7; i++) begin
         rd(addrs[i], d, v);
         vectors++;
         if ({v, d} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_reg[%0d]: rvalid=%b rdata=%h expected rvalid=1 rdata=00000000", addrs[i], v, d);
         end
      end
      tick();
      vectors++;
      if ({rvalid, rdata} !== 33'd0) begin
         miscompares++;
         $display("FAIL rvalid_pulse: rvalid=%b rdata=%h expected 0 0", rvalid, rdata);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      logic        v;
      count = '0;
      wr(A_CMP_LO, 32'h10);
      wr(A_CMP_HI, 32'h0);
      wr(A_CTRL, 32'h5);
      step(16);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL oneshot_early: irq=%b expected 0", irq);
      end
      tick();
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL oneshot_irq: irq=%b expected 1", irq);
      end
      rd(A_CTRL, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h4}) begin
         miscompares++;
         $display("FAIL oneshot_ctrl: rvalid=%b rdata=%h expected 1 00000004", v, d);
      end
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h10}) begin
         miscompares++;
         $display("FAIL oneshot_cmp_hold: rvalid=%b rdata=%h expected 1 00000010", v, d);
      end
      wr(A_STATUS, 32'h0);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL w0_no_clear: irq=%b expected 1", irq);
      end
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, d, v);
      vectors++;
      if ({irq, v, d} !== {1'b0, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL w1c_clear: irq=%b rvalid=%b rdata=%h expected 0 1 00000000", irq, v, d);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] d;
      logic        v;
      count = '0;
      wr(A_PERIOD, 32'h8);
      wr(A_CTRL, 32'h7);
      step(16);
      tick();
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_first_irq: irq=%b expected 1", irq);
      end
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h18}) begin
         miscompares++;
         $display("FAIL reload_cmp_18: rvalid=%b rdata=%h expected 1 00000018", v, d);
      end
      rd(A_CTRL, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h7}) begin
         miscompares++;
         $display("FAIL reload_ctrl: rvalid=%b rdata=%h expected 1 00000007", v, d);
      end
      step(8);
      tick();
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h20}) begin
         miscompares++;
         $display("FAIL reload_cmp_20: rvalid=%b rdata=%h expected 1 00000020", v, d);
      end
      step(8);
      tick();
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h28}) begin
         miscompares++;
         $display("FAIL reload_cmp_28: rvalid=%b rdata=%h expected 1 00000028", v, d);
      end
   endtask

   task automatic test_set_wins();
      logic [31:0] d;
      logic        v;
      wr(A_STATUS, 32'h1);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL setwins_pre_clear: irq=%b expected 0", irq);
      end
      @(negedge clk);
      count = 36'h28; wr_en = 1'b1; addr = A_STATUS; wdata = 32'h1;
      @(negedge clk);
      wr_en = 1'b0; wdata = '0;
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL setwins_irq: irq=%b expected 1", irq);
      end
      rd(A_STATUS, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h1}) begin
         miscompares++;
         $display("FAIL setwins_status: rvalid=%b rdata=%h expected 1 00000001", v, d);
      end
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, d, v);
      vectors++;
      if ({irq, v, d} !== {1'b0, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL setwins_later_clear: irq=%b rvalid=%b rdata=%h expected 0 1 00000000", irq, v, d);
      end
   endtask

   task automatic test_cmp_collision();
      logic [31:0] d;
      logic        v;
      @(negedge clk);
      count = 36'h30; wr_en = 1'b1; addr = A_CMP_LO; wdata = 32'h100;
      @(negedge clk);
      wr_en = 1'b0; wdata = '0;
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL cmpcoll_irq: irq=%b expected 1", irq);
      end
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h100}) begin
         miscompares++;
         $display("FAIL cmpcoll_cpu_wins: rvalid=%b rdata=%h expected 1 00000100", v, d);
      end
      wr(A_STATUS, 32'h1);
      wr(A_CTRL, 32'h0);
      rd(A_CTRL, d, v);
      vectors++;
      if ({irq, v, d} !== {1'b0, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL disable_ctrl: irq=%b rvalid=%b rdata=%h expected 0 1 00000000", irq, v, d);
      end
   endtask

   task automatic test_snapshot();
      logic [31:0] d;
      logic        v;
      count = 36'hA_1234_5678;
      @(negedge clk);
      rd_en = 1'b1; addr = A_SNAP_LO;
      @(negedge clk);
      rd_en = 1'b0;
      d = rdata; v = rvalid;
      count = 36'hB_0000_0001;
      vectors++;
      if ({v, d} !== {1'b1, 32'h1234_5678}) begin
         miscompares++;
         $display("FAIL snap_lo: rvalid=%b rdata=%h expected 1 12345678", v, d);
      end
      rd(A_SNAP_HI, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'hA}) begin
         miscompares++;
         $display("FAIL snap_hi: rvalid=%b rdata=%h expected 1 0000000a", v, d);
      end
      wr(A_SNAP_HI, 32'hFFFF);
      rd(A_SNAP_HI, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'hA}) begin
         miscompares++;
         $display("FAIL snap_hi_ro: rvalid=%b rdata=%h expected 1 0000000a", v, d);
      end
      wr(A_RSVD, 32'hFFFF_FFFF);
      rd(A_RSVD, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL reserved: rvalid=%b rdata=%h expected 1 00000000", v, d);
      end
      wr(A_CTRL, 32'hFFFF_FFFA);
      rd(A_CTRL, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h2}) begin
         miscompares++;
         $display("FAIL ctrl_mask: rvalid=%b rdata=%h expected 1 00000002", v, d);
      end
      wr(A_CTRL, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic        v;
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b1; addr = A_PERIOD; wdata = 32'h55;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
      vectors++;
      if ({rvalid, rdata} !== {1'b1, 32'h8}) begin
         miscompares++;
         $display("FAIL rw_same_cycle: rvalid=%b rdata=%h expected 1 00000008", rvalid, rdata);
      end
      rd(A_PERIOD, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h55}) begin
         miscompares++;
         $display("FAIL rw_new_period: rvalid=%b rdata=%h expected 1 00000055", v, d);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      logic        v;
      wr(A_PERIOD, 32'h8);
      wr(A_CMP_LO, 32'hFFFF_FFFC);
      wr(A_CMP_HI, 32'hF);
      count = 36'hF_FFFF_FFF8;
      wr(A_CTRL, 32'h7);
      step(4);
      tick();
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_top_irq: irq=%b expected 1", irq);
      end
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h4}) begin
         miscompares++;
         $display("FAIL wrap_cmp_lo: rvalid=%b rdata=%h expected 1 00000004", v, d);
      end
      rd(A_CMP_HI, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL wrap_cmp_hi: rvalid=%b rdata=%h expected 1 00000000", v, d);
      end
      wr(A_STATUS, 32'h1);
      step(7);
      tick();
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_early: irq=%b expected 0 (count=%h)", irq, count);
      end
      step(1);
      tick();
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_match_4: irq=%b expected 1", irq);
      end
      rd(A_CMP_LO, d, v);
      vectors++;
      if ({v, d} !== {1'b1, 32'hC}) begin
         miscompares++;
         $display("FAIL wrap_cmp_next: rvalid=%b rdata=%h expected 1 0000000c", v, d);
      end
   endtask

   task automatic test_reset_collision();
      logic [31:0] d;
      logic        v;
      logic [2:0]  addrs [6];
      addrs = '{A_CTRL, A_STATUS, A_CMP_LO, A_CMP_HI, A_PERIOD, A_SNAP_HI};
      wr(A_STATUS, 32'h1);
      @(negedge clk);
      count = 36'hC; reset = 1'b1; rd_en = 1'b1; addr = A_CMP_LO;
      @(negedge clk);
      reset = 1'b0; rd_en = 1'b0;
      vectors++;
      if ({irq, rvalid, rdata} !== 34'd0) begin
         miscompares++;
         $display("FAIL rstcoll_outputs: irq=%b rvalid=%b rdata=%h expected all 0", irq, rvalid, rdata);
      end
      for (int i = 0; i < 6; i++) begin
         rd(addrs[i], d, v);
         vectors++;
         if ({v, d} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL rstcoll_reg[%0d]: rvalid=%b rdata=%h expected 1 00000000", addrs[i], v, d);
         end
      end
      tick();
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL rstcoll_irq_idle: irq=%b expected 0", irq);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_set_wins();
      test_cmp_collision();
      test_snapshot();
      test_back_to_back();
      test_wrap();
      test_reset_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/timer_cmp.md
TIMER_CMP -- requirements
Module: timer_cmp

Interface
REQ-001 Parameter WIDTH, default 36: width of the free-running count input and of the compare register.
REQ-002 Parameter PERIOD_W, default 32: width of the auto-reload period register.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port count, input, WIDTH: free-running value from the upstream counter, sampled every cycle.
REQ-006 Port wr_en, input, 1: register write strobe, one write per asserted cycle.
REQ-007 Port rd_en, input, 1: register read strobe.
REQ-008 Port addr, input, 3: register index (0 CTRL, 1 STATUS, 2 CMP_LO, 3 CMP_HI, 4 PERIOD, 5 SNAP_LO, 6 SNAP_HI, 7 reserved).
REQ-009 Port wdata, input, 32: write data.
REQ-010 Port rdata, output, 32: read data, valid when rvalid is high.
REQ-011 Port rvalid, output, 1: one-cycle read-response pulse.
REQ-012 Port irq, output, 1: level interrupt, equal to STATUS.pending AND CTRL.irq_en.

Function
REQ-013 CTRL bits: bit0 enable, bit1 autoreload, bit2 irq_en; all other bits read 0 and ignore writes.
REQ-014 State machine: IDLE (enable=0), ARMED (enable=1); a write of enable=0 from any state returns to IDLE in the next cycle; pending is unaffected by state changes.
REQ-015 Match: in ARMED, a cycle with count == CMP (full WIDTH, equality only) sets STATUS.pending in the next cycle.
REQ-016 A CMP already passed by count does not fire until count wraps modulo 2^WIDTH and equals CMP again.
REQ-017 Autoreload: on a match with autoreload=1, CMP <= (CMP + zero-extended PERIOD) mod 2^WIDTH in the same edge that sets pending.
REQ-018 One-shot: on a match with autoreload=0, CMP holds and the state returns to IDLE, with CTRL.enable cleared by hardware.
REQ-019 STATUS bit0 pending is write-1-to-clear; writing 0 has no effect.
REQ-020 Simultaneous match and W1C of pending in the same cycle: pending remains 1 (set wins).
REQ-021 Simultaneous match and CPU write to CMP_LO/CMP_HI in the same cycle: the match uses the old CMP; the CPU write wins over the autoreload update.
REQ-022 CMP_LO holds CMP[31:0]; CMP_HI holds CMP[WIDTH-1:32]; unused upper bits read 0.
REQ-023 A read of SNAP_LO returns count[31:0] and, in the same edge, captures count[WIDTH-1:32] into a SNAP_HI holding register; SNAP_HI reads return that capture, giving a coherent 36-bit value.
REQ-024 SNAP_LO and SNAP_HI writes are ignored; reads of address 7 return 0.
REQ-025 Read latency is exactly 1 cycle: rd_en at edge N yields rvalid=1 and rdata during cycle N+1; rdata is 0 when rvalid=0.
REQ-026 A read and a write in the same cycle are both performed; the read returns the pre-write value.

Reset
REQ-027 Reset clears CTRL, pending, CMP, PERIOD and SNAP_HI to 0, selects IDLE, and drives rvalid=0, rdata=0, irq=0 from the next edge.
REQ-028 Reset asserted mid-operation overrides any simultaneous match, read or write in that cycle.

Structure
REQ-029 Register address constants and CTRL/STATUS bit positions live in a shared package/include used by the bus decoder and by firmware headers.
REQ-030 One sub-module, timer_cmp_regs (register file, read mux and snapshot), is instantiated by timer_cmp; match logic and the state machine stay in the top level.

Verification
REQ-031 CMP=0x10, CTRL=0b101, count ramps from 0 -> pending set the cycle after count=0x10; irq=1; CTRL.enable reads 0.
REQ-032 CMP=0x10, PERIOD=8, CTRL=0b111 -> matches at 0x10, 0x18 and 0x20; CMP reads 0x28 afterwards.
REQ-033 Match and STATUS W1C in the same cycle -> pending stays 1; a later W1C -> pending 0, irq 0.
REQ-034 count=0xA_1234_5678, read SNAP_LO then SNAP_HI while count advances -> 0x12345678 and 0xA, each with rvalid one cycle after rd_en.
REQ-035 CMP=0xF_FFFF_FFFC, PERIOD=8, autoreload -> after the match, CMP wraps to 0x4; next match at count=0x4 after count wraps.
REQ-036 reset pulsed in the same cycle as a match -> pending 0, all registers 0, irq 0.
